// File: rtl/regfile_dump.sv
// NREG x DW register file: gated write port, two async read ports, per-register dirty flags and
// a valid/ready dump sequencer. Define WRITE_BYPASS_EN to forward a same-cycle write to the reads.
module regfile_dump #(
    parameter int unsigned   DW        = 16,
    parameter int unsigned   NREG      = 4,
    parameter logic [DW-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] rd,
    input  logic [DW-1:0]           result,
    input  logic [$clog2(NREG)-1:0] rs_a,
    input  logic [$clog2(NREG)-1:0] rs_b,
    output logic [DW-1:0]           o_a,
    output logic [DW-1:0]           o_b,
    output logic [NREG-1:0]         o_dirty,
    input  logic                    dump_start,
    output logic                    dump_busy,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic [$clog2(NREG)-1:0] dump_idx,
    output logic [DW-1:0]           dump_data,
    output logic                    dump_last
);

    localparam int unsigned     AW       = $clog2(NREG);
    localparam logic [AW:0]     NREG_W   = (AW+1)'(NREG);
    localparam logic [AW-1:0]   LAST_IDX = AW'(NREG - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_dirty;
    logic [NREG-1:0] w_dirty_next;
    state_e          r_state;
    state_e          w_state_next;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_next;
    logic [AW-1:0]   w_idx_inc;
    logic [DW-1:0]   r_data;
    logic [DW-1:0]   w_data_next;
    logic            w_wr_en;
    logic            w_xfer;
    logic            w_rs_a_ok;
    logic            w_rs_b_ok;
    logic [DW-1:0]   w_a;
    logic [DW-1:0]   w_b;

    // Indices beyond NREG-1 only exist when NREG is not a power of two.
    assign w_wr_en   = we && ({1'b0, rd} < NREG_W);
    assign w_rs_a_ok = {1'b0, rs_a} < NREG_W;
    assign w_rs_b_ok = {1'b0, rs_b} < NREG_W;
    assign w_xfer    = (r_state == StSend) && dump_ready;
    assign w_idx_inc = r_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else if (w_wr_en) begin
            r_regs[rd] <= result;
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        if (w_rs_a_ok) begin
            w_a = r_regs[rs_a];
        end
        if (w_rs_b_ok) begin
            w_b = r_regs[rs_b];
        end
`ifdef WRITE_BYPASS_EN
        if (w_wr_en && (rd == rs_a)) begin
            w_a = result;
        end
        if (w_wr_en && (rd == rs_b)) begin
            w_b = result;
        end
`endif
    end

    assign o_a = w_a;
    assign o_b = w_b;

    // A write on the same edge as the transfer of that index must leave the bit set.
    always_comb begin
        w_dirty_next = r_dirty;
        if (w_xfer) begin
            w_dirty_next[r_idx] = 1'b0;
        end
        if (w_wr_en) begin
            w_dirty_next[rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= w_dirty_next;
        end
    end

    assign o_dirty = r_dirty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_data  <= w_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (dump_start) begin
                    w_state_next = StSend;
                end
            end
            StSend: begin
                if (dump_ready && (r_idx == LAST_IDX)) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Captures read r_regs before the edge, so a concurrent write is never seen by the dump.
    always_comb begin
        w_idx_next  = r_idx;
        w_data_next = r_data;
        if ((r_state == StIdle) && dump_start) begin
            w_idx_next  = '0;
            w_data_next = r_regs[0];
        end else if (w_xfer && (r_idx != LAST_IDX)) begin
            w_idx_next  = w_idx_inc;
            w_data_next = r_regs[w_idx_inc];
        end
    end

    always_comb begin
        dump_busy  = (r_state == StSend);
        dump_valid = (r_state == StSend);
        dump_last  = (r_state == StSend) && (r_idx == LAST_IDX);
        dump_idx   = r_idx;
        dump_data  = r_data;
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: directed scenarios followed by randomized traffic,
// all compared against an array/queue-level behavioural model.
module tb_regfile_dump;

    localparam int DW   = 16;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            we;
    logic [AW-1:0]   rd;
    logic [DW-1:0]   result;
    logic [AW-1:0]   rs_a;
    logic [AW-1:0]   rs_b;
    logic [DW-1:0]   o_a;
    logic [DW-1:0]   o_b;
    logic [NREG-1:0] o_dirty;
    logic            dump_start;
    logic            dump_busy;
    logic            dump_valid;
    logic            dump_ready;
    logic [AW-1:0]   dump_idx;
    logic [DW-1:0]   dump_data;
    logic            dump_last;

    always #5 clk = ~clk;

    regfile_dump #(
        .DW       (DW),
        .NREG     (NREG),
        .RESET_VAL(16'h0000)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .rd        (rd),
        .result    (result),
        .rs_a      (rs_a),
        .rs_b      (rs_b),
        .o_a       (o_a),
        .o_b       (o_b),
        .o_dirty   (o_dirty),
        .dump_start(dump_start),
        .dump_busy (dump_busy),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_idx  (dump_idx),
        .dump_data (dump_data),
        .dump_last (dump_last)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model: register array, dirty bits, and the dump position.
    logic [DW-1:0]   m_regs [NREG];
    logic [NREG-1:0] m_dirty;
    bit              m_busy;
    int              m_pos;
    logic [DW-1:0]   m_data;

    logic [DW-1:0] t2_vals [NREG] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_dirty = '0;
        m_busy  = 1'b0;
        m_pos   = 0;
        m_data  = '0;
    endtask

    task automatic model_step();
        if (!m_busy) begin
            if (dump_start) begin
                m_busy = 1'b1;
                m_pos  = 0;
                m_data = m_regs[0];
            end
        end else if (dump_ready) begin
            m_dirty[m_pos] = 1'b0;
            if (m_pos == NREG - 1) begin
                m_busy = 1'b0;
            end else begin
                m_pos++;
                m_data = m_regs[m_pos];
            end
        end
        if (we) begin
            m_regs[rd]  = result;
            m_dirty[rd] = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] idx);
        logic [DW-1:0] v;
        v = m_regs[idx];
`ifdef WRITE_BYPASS_EN
        if (we && (rd == idx)) v = result;
`endif
        return v;
    endfunction

    task automatic check_outputs();
        check_eq("o_a", 32'(o_a), 32'(exp_read(rs_a)));
        check_eq("o_b", 32'(o_b), 32'(exp_read(rs_b)));
        check_eq("o_dirty", 32'(o_dirty), 32'(m_dirty));
        check_eq("dump_busy", 32'(dump_busy), 32'(m_busy));
        check_eq("dump_valid", 32'(dump_valid), 32'(m_busy));
        check_eq("dump_idx", 32'(dump_idx), 32'(m_pos));
        check_eq("dump_data", 32'(dump_data), 32'(m_data));
        check_eq("dump_last", 32'(dump_last), 32'(m_busy && (m_pos == NREG - 1)));
    endtask

    // Inputs are set at the falling edge; outputs are checked before the rising edge.
    task automatic run_cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        we         = 1'b0;
        rd         = '0;
        result     = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
    endtask

    task automatic write_reg(input int idx, input logic [DW-1:0] val);
        we     = 1'b1;
        rd     = AW'(idx);
        result = val;
        run_cycle();
        we     = 1'b0;
    endtask

    // Reset asserted between clock edges to exercise the asynchronous path.
    task automatic reset_mid_cycle();
        set_idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_valid", 32'(dump_valid), 32'd0);
        check_eq("rst_busy", 32'(dump_busy), 32'd0);
        check_eq("rst_dirty", 32'(o_dirty), 32'd0);
        for (int i = 0; i < NREG; i++) begin
            rs_a = AW'(i);
            #0.1;
            check_eq("rst_reg", 32'(o_a), 32'h0000);
        end
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        rs_a  = '0;
        rs_b  = '0;
        set_idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state
        #1;
        check_eq("t1_o_a", 32'(o_a), 32'h0);
        check_eq("t1_o_b", 32'(o_b), 32'h0);
        check_eq("t1_dirty", 32'(o_dirty), 32'h0);
        check_eq("t1_busy", 32'(dump_busy), 32'h0);
        check_eq("t1_valid", 32'(dump_valid), 32'h0);
        check_eq("t1_idx", 32'(dump_idx), 32'h0);
        run_cycle();

        // 2: fill, read back, gated write
        for (int i = 0; i < NREG; i++) write_reg(i, t2_vals[i]);
        rs_a = 2'd2;
        rs_b = 2'd3;
        #1;
        check_eq("t2_o_a", 32'(o_a), 32'hCCCC);
        check_eq("t2_o_b", 32'(o_b), 32'hDDDD);
        check_eq("t2_dirty", 32'(o_dirty), 32'hF);
        we = 1'b0; rd = 2'd1; result = 16'h1234;
        run_cycle();
        rs_a = 2'd1;
        #1;
        check_eq("t2_gated", 32'(o_a), 32'hBBBB);
        run_cycle();

        // 4: full dump with ready tied high
        dump_start = 1'b1;
        dump_ready = 1'b1;
        run_cycle();
        dump_start = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            #1;
            check_eq("t4_idx", 32'(dump_idx), 32'(i));
            check_eq("t4_data", 32'(dump_data), 32'(t2_vals[i]));
            check_eq("t4_last", 32'(dump_last), 32'(i == NREG - 1));
            run_cycle();
        end
        #1;
        check_eq("t4_busy", 32'(dump_busy), 32'h0);
        check_eq("t4_dirty", 32'(o_dirty), 32'h0);
        run_cycle();

        // 3: same-cycle read of the register being written
        we = 1'b1; rd = 2'd1; result = 16'h5555; rs_a = 2'd1;
        #1;
`ifdef WRITE_BYPASS_EN
        check_eq("t3_bypass", 32'(o_a), 32'h5555);
`else
        check_eq("t3_nobypass", 32'(o_a), 32'hBBBB);
`endif
        run_cycle();
        we = 1'b0;
        #1;
        check_eq("t3_after", 32'(o_a), 32'h5555);
        run_cycle();

        // 5: stall at idx 1 while overwriting r1
        write_reg(1, 16'hBBBB);
        dump_start = 1'b1;
        dump_ready = 1'b1;
        run_cycle();
        dump_start = 1'b0;
        run_cycle();
        dump_ready = 1'b0;
        we = 1'b1; rd = 2'd1; result = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("t5_hold_idx", 32'(dump_idx), 32'd1);
            check_eq("t5_hold_data", 32'(dump_data), 32'hBBBB);
            run_cycle();
        end
        dump_ready = 1'b1;
        run_cycle();
        we = 1'b0;
        #1;
        check_eq("t5_adv_idx", 32'(dump_idx), 32'd2);
        check_eq("t5_adv_data", 32'(dump_data), 32'hCCCC);
        check_eq("t5_dirty1", 32'(o_dirty[1]), 32'd1);

        // 6: reset mid-dump at idx 2, then a fresh dump starts at idx 0
        reset_mid_cycle();
        dump_start = 1'b1;
        dump_ready = 1'b1;
        run_cycle();
        dump_start = 1'b0;
        #1;
        check_eq("t6_valid", 32'(dump_valid), 32'd1);
        check_eq("t6_idx", 32'(dump_idx), 32'd0);
        run_cycle();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            we         = ($urandom_range(0, 1) == 1);
            rd         = AW'($urandom_range(0, NREG - 1));
            result     = DW'($urandom);
            rs_a       = AW'($urandom_range(0, NREG - 1));
            rs_b       = AW'($urandom_range(0, NREG - 1));
            dump_start = ($urandom_range(0, 3) == 0);
            dump_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 59) == 0) begin
                reset_mid_cycle();
            end else begin
                run_cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
